rtc_field_editor: RTL and testbench

Parametrised editor for packed-BCD date/time/timer fields destined for the RTC write path. It replaces the fixed nine-field push-button edit path with a generic N-field editor that provides:
- cursor navigation, with the cursor shown on a one-hot Habilita output;
- per-field BCD min/max wrap;
- auto-repeat on held buttons;
- month/leap-aware day clamping;
- separate commit handshakes for the date/time group and the timer group.

It sits between the button inputs and the RTC controller. Its field bus also feeds the VGA display path.

---
 rtl/rtc_pkg.sv | 72 +++++++
 rtl/btn_step_gen.sv | 59 +++++
 rtl/rtc_field_editor.sv | 169 ++++++++++++++++
 tb/tb_rtc_field_editor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared field indices, default bounds, editor state encoding and BCD/calendar helpers.
// Pure declarations: no latency, no flow control.
package rtc_pkg;

  localparam int F_ANO  = 0;
  localparam int F_MES  = 1;
  localparam int F_DIA  = 2;
  localparam int F_HORA = 3;
  localparam int F_MIN  = 4;
  localparam int F_SEG  = 5;
  localparam int F_TH   = 6;
  localparam int F_TM   = 7;
  localparam int F_ST   = 8;

  localparam int DEF_NUM_FIELDS = 9;

  // Index 0 (year) sits in the least significant byte.
  localparam logic [71:0] DEF_MIN_VEC =
    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
  localparam logic [71:0] DEF_MAX_VEC =
    {8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0)     r = {v[7:4] - 4'd1, 4'd9};
    else if (v[3:0] > 4'd9) r = {v[7:4], 4'd9};
    else                    r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Out-of-range values snap to the nearest bound instead of stepping.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi, input logic up);
    logic [7:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else if (up)     r = (v == hi) ? lo : bcd_inc(v);
    else             r = (v == lo) ? hi : bcd_dec(v);
    return r;
  endfunction

  function automatic logic is_leap(input logic [7:0] year);
    logic [3:0] u;
    u = year[3:0];
    return (!year[4] && (u == 4'd0 || u == 4'd4 || u == 4'd8)) ||
           ( year[4] && (u == 4'd2 || u == 4'd6));
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
    logic [7:0] r;
    case (month)
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      8'h02:                      r = is_leap(year) ? 8'h29 : 8'h28;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_step_gen.sv
// Button conditioner: 2-flop sync, rising-edge step pulse (3 cycles pin->pulse), optional auto-repeat.
// No backpressure: one-cycle step pulses are produced whether or not they are consumed.
module btn_step_gen #(
  parameter bit REPEAT_EN  = 1'b0,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step
);

  localparam logic [31:0] DLY_C = 32'(REPEAT_DLY);
  localparam logic [31:0] CYC_C = 32'(REPEAT_CYC);

  logic        sync0, sync1, sync2;
  logic [31:0] hold_cnt;
  logic        in_cyc;
  logic        rise;
  logic        rep_hit;
  logic        rep_fire;

  assign rise     = sync1 & ~sync2;
  assign rep_hit  = in_cyc ? (hold_cnt == CYC_C) : (hold_cnt == DLY_C);
  assign rep_fire = REPEAT_EN && sync1 && sync2 && rep_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      hold_cnt <= '0;
      in_cyc   <= 1'b0;
      step     <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      sync2 <= sync1;
      step  <= rise | rep_fire;
      // hold_cnt counts the cycles the synchronised button has been high
      if (rise) begin
        hold_cnt <= 32'd1;
        in_cyc   <= 1'b0;
      end else if (sync1) begin
        if (rep_hit) begin
          hold_cnt <= 32'd1;
          in_cyc   <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 32'd1;
        end
      end else begin
        hold_cnt <= '0;
        in_cyc   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rtc_field_editor.sv
// N-field packed-BCD editor with cursor, wrap, auto-repeat, day clamping and group commit.
// Steps land 4 cycles after a button pin edge; listo_es/listo_ht hold until wr_ack.
module rtc_field_editor
  import rtc_pkg::*;
#(
  parameter int                          NUM_FIELDS = DEF_NUM_FIELDS,
  parameter logic [8*NUM_FIELDS-1:0]     MIN_VEC    = DEF_MIN_VEC,
  parameter logic [8*NUM_FIELDS-1:0]     MAX_VEC    = DEF_MAX_VEC,
  parameter logic [NUM_FIELDS-1:0]       TIMER_MASK = 9'b111000000,
  parameter int                          REPEAT_DLY = 25_000_000,
  parameter int                          REPEAT_CYC = 5_000_000,
  parameter bit                          DAY_LINK   = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      aumenta,
  input  logic                      disminuye,
  input  logic                      siguiente,
  input  logic                      anterior,
  input  logic                      edit_en,
  input  logic                      commit,
  input  logic [8*NUM_FIELDS-1:0]   live_in,
  input  logic                      wr_ack,
  output logic [8*NUM_FIELDS-1:0]   fields_out,
  output logic [NUM_FIELDS-1:0]     habilita,
  output logic                      listo_es,
  output logic                      listo_ht
);

  localparam int          CW     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(NUM_FIELDS - 1);

  logic st_aum, st_dis, st_sig, st_ant;

  btn_step_gen #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
    u_aum (.clk(clk), .reset(reset), .btn(aumenta),   .step(st_aum));
  btn_step_gen #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
    u_dis (.clk(clk), .reset(reset), .btn(disminuye), .step(st_dis));
  btn_step_gen #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
    u_sig (.clk(clk), .reset(reset), .btn(siguiente), .step(st_sig));
  btn_step_gen #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC))
    u_ant (.clk(clk), .reset(reset), .btn(anterior),  .step(st_ant));

  state_t                    state, state_n;
  logic [CW-1:0]             cursor, cursor_n;
  logic [8*NUM_FIELDS-1:0]   fields, fields_n;
  logic                      mod_es, mod_es_n;
  logic                      mod_ht, mod_ht_n;
  logic                      listo_es_n, listo_ht_n;

  logic                      up, dn, fwd, bwd;
  logic [7:0]                cur_val, cur_lo, cur_hi, new_val, dim_n;
  logic                      cur_timer;

  assign up  = st_aum & ~st_dis;
  assign dn  = st_dis & ~st_aum;
  assign fwd = st_sig & ~st_ant;
  assign bwd = st_ant & ~st_sig;

  // Selected field and its bounds; the day ceiling follows the current month/year.
  always_comb begin
    cur_val   = 8'h00;
    cur_lo    = 8'h00;
    cur_hi    = 8'h00;
    cur_timer = 1'b0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (cursor == CW'(i)) begin
        cur_val   = fields[8*i +: 8];
        cur_lo    = MIN_VEC[8*i +: 8];
        cur_hi    = MAX_VEC[8*i +: 8];
        cur_timer = TIMER_MASK[i];
      end
    end
    if (DAY_LINK && cursor == CW'(F_DIA))
      cur_hi = days_in_month(fields[8*F_MES +: 8], fields[8*F_ANO +: 8]);
    new_val = bcd_step(cur_val, cur_lo, cur_hi, up);
  end

  always_comb begin
    state_n    = state;
    cursor_n   = cursor;
    fields_n   = fields;
    mod_es_n   = mod_es;
    mod_ht_n   = mod_ht;
    listo_es_n = listo_es;
    listo_ht_n = listo_ht;
    dim_n      = 8'h31;

    case (state)
      IDLE: begin
        fields_n   = live_in;
        mod_es_n   = 1'b0;
        mod_ht_n   = 1'b0;
        listo_es_n = 1'b0;
        listo_ht_n = 1'b0;
        if (edit_en) begin
          state_n  = EDIT;
          cursor_n = '0;
        end
      end

      EDIT: begin
        if (!edit_en) begin
          state_n = IDLE;
        end else if (commit) begin
          if (mod_es || mod_ht) begin
            state_n    = WAIT_ACK;
            listo_es_n = mod_es;
            listo_ht_n = mod_ht;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (up || dn) begin
            for (int i = 0; i < NUM_FIELDS; i++)
              if (cursor == CW'(i)) fields_n[8*i +: 8] = new_val;
            if (cur_timer) mod_ht_n = 1'b1;
            else           mod_es_n = 1'b1;
            // A month/year change can leave the day past the new month end.
            if (DAY_LINK && (cursor == CW'(F_MES) || cursor == CW'(F_ANO))) begin
              dim_n = days_in_month(fields_n[8*F_MES +: 8], fields_n[8*F_ANO +: 8]);
              if (fields_n[8*F_DIA +: 8] > dim_n) fields_n[8*F_DIA +: 8] = dim_n;
            end
          end
          if (fwd)      cursor_n = (cursor == LAST_C) ? '0 : cursor + CW'(1);
          else if (bwd) cursor_n = (cursor == '0) ? LAST_C : cursor - CW'(1);
        end
      end

      WAIT_ACK: begin
        if (wr_ack) begin
          state_n    = IDLE;
          listo_es_n = 1'b0;
          listo_ht_n = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cursor   <= '0;
      fields   <= MIN_VEC;
      mod_es   <= 1'b0;
      mod_ht   <= 1'b0;
      listo_es <= 1'b0;
      listo_ht <= 1'b0;
    end else begin
      state    <= state_n;
      cursor   <= cursor_n;
      fields   <= fields_n;
      mod_es   <= mod_es_n;
      mod_ht   <= mod_ht_n;
      listo_es <= listo_es_n;
      listo_ht <= listo_ht_n;
    end
  end

  assign fields_out = fields;

  always_comb begin
    habilita = '0;
    if (state == EDIT) habilita[cursor] = 1'b1;
  end

endmodule

// File: tb/tb_rtc_field_editor.sv
// Directed bench for rtc_field_editor with short auto-repeat timing.
module tb_rtc_field_editor;

  localparam int NF  = 9;
  localparam int DLY = 20;
  localparam int CYC = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            aumenta = 1'b0, disminuye = 1'b0, siguiente = 1'b0, anterior = 1'b0;
  logic            edit_en = 1'b0, commit = 1'b0, wr_ack = 1'b0;
  logic [8*NF-1:0] live_in = '0;
  logic [8*NF-1:0] fields_out;
  logic [NF-1:0]   habilita;
  logic            listo_es, listo_ht;

  int n_chk  = 0;
  int n_fail = 0;

  rtc_field_editor #(.REPEAT_DLY(DLY), .REPEAT_CYC(CYC)) dut (
    .clk(clk), .reset(reset), .aumenta(aumenta), .disminuye(disminuye),
    .siguiente(siguiente), .anterior(anterior), .edit_en(edit_en), .commit(commit),
    .live_in(live_in), .wr_ack(wr_ack), .fields_out(fields_out), .habilita(habilita),
    .listo_es(listo_es), .listo_ht(listo_ht)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0=aumenta 1=disminuye 2=siguiente 3=anterior
  task automatic press(input int b);
    case (b)
      0: aumenta = 1'b1;
      1: disminuye = 1'b1;
      2: siguiente = 1'b1;
      default: anterior = 1'b1;
    endcase
    tick(2);
    aumenta = 1'b0; disminuye = 1'b0; siguiente = 1'b0; anterior = 1'b0;
    tick(5);
  endtask

  function automatic logic [71:0] mk(input logic [7:0] y, mo, d, h, mi, s, th, tm, ts);
    return {ts, tm, th, s, mi, h, d, mo, y};
  endfunction

  logic [71:0] lv;

  initial begin
    live_in = mk(8'h26, 8'h03, 8'h15, 8'h22, 8'h59, 8'h00, 8'h00, 8'h05, 8'h00);
    tick(3);
    chk("reset_fields", fields_out, 72'h00_00_00_00_00_00_01_01_00);
    chk("reset_hab", habilita, 0);
    chk("reset_listo", {listo_es, listo_ht}, 0);

    reset = 1'b0;
    tick(2);
    chk("idle_track", fields_out, live_in);

    // cursor to hour, two increments 22 -> 23 -> 00
    edit_en = 1'b1;
    tick(1);
    chk("edit_hab0", habilita, 9'b000000001);
    live_in = mk(8'h99, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09);
    press(2); press(2); press(2);
    press(0); press(0);
    chk("hab_hour", habilita, 9'b000001000);
    chk("hour_wrap", fields_out[31:24], 8'h00);
    chk("year_frozen", fields_out[7:0], 8'h26);

    press(2);
    press(0);
    chk("min_59_up", fields_out[39:32], 8'h00);
    press(1);
    chk("min_00_dn", fields_out[39:32], 8'h59);

    edit_en = 1'b0;
    live_in = mk(8'h26, 8'h03, 8'h15, 8'h22, 8'h09, 8'h00, 8'h00, 8'h05, 8'h00);
    tick(2);
    chk("discard_track", fields_out, live_in);
    edit_en = 1'b1;
    tick(1);
    press(2); press(2); press(2); press(2);
    press(0);
    chk("min_bcd_carry", fields_out[39:32], 8'h10);
    press(1);
    chk("min_bcd_borrow", fields_out[39:32], 8'h09);

    // leap-year day clamp on month and year changes
    edit_en = 1'b0;
    live_in = mk(8'h24, 8'h03, 8'h31, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00);
    tick(2);
    edit_en = 1'b1;
    tick(1);
    press(2);
    press(1);
    chk("leap_month", fields_out[15:8], 8'h02);
    chk("leap_day29", fields_out[23:16], 8'h29);
    press(3);
    press(1);
    chk("year_dn", fields_out[7:0], 8'h23);
    chk("year_clamp28", fields_out[23:16], 8'h28);

    edit_en = 1'b0;
    live_in = mk(8'h25, 8'h03, 8'h31, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00);
    tick(2);
    edit_en = 1'b1;
    tick(1);
    press(2);
    press(1);
    chk("noleap_day28", fields_out[23:16], 8'h28);

    // timer-only edit and commit
    edit_en = 1'b0;
    live_in = mk(8'h26, 8'h03, 8'h15, 8'h10, 8'h20, 8'h30, 8'h01, 8'h05, 8'h07);
    tick(2);
    edit_en = 1'b1;
    tick(1);
    press(3); press(3);
    chk("hab_wrap_back", habilita, 9'b010000000);
    press(0);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    tick(1);
    chk("commit_listo", {listo_es, listo_ht}, 2'b01);
    chk("wait_hab", habilita, 0);
    edit_en = 1'b0;
    lv = mk(8'h26, 8'h03, 8'h15, 8'h10, 8'h20, 8'h30, 8'h01, 8'h40, 8'h07);
    live_in = lv;
    press(0);
    chk("wait_hold_listo", {listo_es, listo_ht}, 2'b01);
    chk("wait_hold_tm", fields_out[63:56], 8'h06);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    chk("ack_listo", {listo_es, listo_ht}, 2'b00);
    tick(1);
    chk("ack_track", fields_out, lv);

    // commit with nothing modified
    edit_en = 1'b1;
    tick(1);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    edit_en = 1'b0;
    chk("nomod_listo", {listo_es, listo_ht}, 2'b00);
    chk("nomod_idle_hab", habilita, 0);

    // auto-repeat on a held aumenta
    live_in = mk(8'h10, 8'h03, 8'h15, 8'h10, 8'h20, 8'h30, 8'h01, 8'h05, 8'h07);
    tick(2);
    edit_en = 1'b1;
    tick(1);
    aumenta = 1'b1;
    tick(DLY + 3 * CYC);
    aumenta = 1'b0;
    tick(6);
    chk("repeat_4", fields_out[7:0], 8'h14);
    aumenta = 1'b1; disminuye = 1'b1;
    tick(2);
    aumenta = 1'b0; disminuye = 1'b0;
    tick(6);
    chk("both_nochange", fields_out[7:0], 8'h14);
    siguiente = 1'b1;
    tick(DLY + 3 * CYC);
    siguiente = 1'b0;
    tick(6);
    chk("sig_no_repeat", habilita, 9'b000000010);

    // reset while a date/time write is pending
    press(0);
    chk("month_up", fields_out[15:8], 8'h04);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    tick(1);
    chk("es_pending", {listo_es, listo_ht}, 2'b10);
    reset = 1'b1;
    tick(1);
    chk("rst_listo", {listo_es, listo_ht}, 2'b00);
    chk("rst_hab", habilita, 0);
    chk("rst_fields", fields_out, 72'h00_00_00_00_00_00_01_01_00);
    reset = 1'b0;
    tick(1);
    chk("rst_cursor0", habilita, 9'b000000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
